// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg
//   Shared types and constants for the memory-side responder slice.
//   - WORD_W / BYTE_LANES : data word width and number of byte lanes
//   - state_t             : responder FSM states (IDLE, WAIT, RESP)
//   - op_t                : latched request operation (OP_RD, OP_WR)
//   - lane_mask()         : expands a per-byte enable into a per-bit mask
package mem_resp_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_LANES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // Expand one enable bit per byte into eight identical mask bits.
  function automatic logic [WORD_W-1:0] lane_mask(input logic [BYTE_LANES-1:0] be);
    logic [WORD_W-1:0] m;
    m = '0;
    for (int i = 0; i < BYTE_LANES; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// mem_resp_ram
//   Word storage for the responder: single-port array of DEPTH words with
//   a synchronous, byte-masked write and a combinational read of the
//   addressed word. The read value is registered by the caller, so the
//   array itself carries no output register.
//   Contents are not reset and are undefined until written.
//
//   Ports:
//     clk    in   clock, write happens on the rising edge
//     we     in   [BYTE_LANES] per-byte write enable (all zero = no write)
//     addr   in   [AW] word index
//     wdata  in   [WORD_W] write data
//     rdata  out  [WORD_W] current contents of word addr
module mem_resp_ram
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic [BYTE_LANES-1:0] we,
  input  logic [AW-1:0]         addr,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Only the enabled byte lanes of the addressed word are updated; the
  // other lanes keep their previous contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BYTE_LANES; i++) begin
      if (we[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the multicycle core's data port. Accepts a
//   one-cycle mem_read / mem_write strobe while idle, waits a fixed
//   LATENCY, performs the access on the edge entering RESP and returns a
//   one-cycle response with read data and an error flag.
//
//   Optional feature macro: MEM_RESP_WSTRB_EN
//     defined   -> wstrb port exists, writes update only the selected byte
//                  lanes (wstrb = 0 is a no-op write that still responds)
//     undefined -> no wstrb port, every write replaces the whole word
//
//   Parameters:
//     DEPTH    number of 32-bit words (power of two, >= 4)
//     LATENCY  cycles from accept edge to rsp_valid (>= 1)
//
//   Ports:
//     clk        in   single clock, rising edge
//     reset      in   synchronous active-high reset
//     mem_read   in   read request strobe
//     mem_write  in   write request strobe
//     addr       in   [32] byte address
//     wdata      in   [32] write data
//     wstrb      in   [4] byte lanes of a write (MEM_RESP_WSTRB_EN only)
//     ready      out  idle, a strobe now will be accepted
//     rsp_valid  out  one-cycle response pulse
//     rsp_err    out  misaligned / out-of-range, qualifies rsp_valid
//     rdata      out  [32] read data, held until the next read response
//     drop       out  sticky: strobe while busy, or both strobes at once
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [WORD_W-1:0]     addr,
  input  logic [WORD_W-1:0]     wdata,
`ifdef MEM_RESP_WSTRB_EN
  input  logic [BYTE_LANES-1:0] wstrb,
`endif
  output logic                  ready,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [WORD_W-1:0]     rdata,
  output logic                  drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t                state;
  logic [CW-1:0]         lat_cnt;
  op_t                   req_op;
  logic [WORD_W-1:0]     req_addr;
  logic [WORD_W-1:0]     req_wdata;
  logic [BYTE_LANES-1:0] req_strb;

  logic                  any_req;
  logic                  both_req;
  logic                  accept;
  logic                  enter_resp;
  logic [BYTE_LANES-1:0] in_strb;
  op_t                   in_op;

  op_t                   cur_op;
  logic [WORD_W-1:0]     cur_addr;
  logic [WORD_W-1:0]     cur_wdata;
  logic [BYTE_LANES-1:0] cur_strb;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  cur_err;

  logic [BYTE_LANES-1:0] ram_we;
  logic [WORD_W-1:0]     ram_rdata;

`ifdef MEM_RESP_WSTRB_EN
  assign in_strb = wstrb;
`else
  assign in_strb = '1;
`endif

  // Request decode. A collision is served as a read, so mem_read wins.
  assign any_req  = mem_read | mem_write;
  assign both_req = mem_read & mem_write;
  assign accept   = (state == IDLE) & any_req;
  assign in_op    = mem_read ? OP_RD : OP_WR;

  // The RESP-entry edge: either straight from IDLE when there is no
  // waiting to do, or from WAIT once the counter has run out.
  always_comb begin
    enter_resp = 1'b0;
    if (state == IDLE) begin
      enter_resp = accept && (LATENCY == 1);
    end else if (state == WAIT) begin
      enter_resp = (lat_cnt == CW'(LATENCY - 1));
    end
  end

  // With LATENCY = 1 the access happens on the same edge that accepts the
  // request, before the request registers hold it, so the access path
  // takes the live inputs while idle and the latched copy otherwise.
  always_comb begin
    if (state == IDLE) begin
      cur_op    = in_op;
      cur_addr  = addr;
      cur_wdata = wdata;
      cur_strb  = in_strb;
    end else begin
      cur_op    = req_op;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_strb  = req_strb;
    end
  end

  // Anything set above the word-index field addresses past the array.
  assign misaligned   = (cur_addr[1:0] != 2'b00);
  assign out_of_range = ((cur_addr >> (AW + 2)) != '0);
  assign cur_err      = misaligned | out_of_range;

  // The write only commits on a clean RESP-entry edge; a reset landing on
  // that same edge aborts it.
  always_comb begin
    ram_we = '0;
    if (enter_resp && !reset && (cur_op == OP_WR) && !cur_err) begin
      ram_we = cur_strb;
    end
  end

  mem_resp_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (cur_addr[2 +: AW]),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

  // Responder FSM, latency counter, request registers and all registered
  // outputs. ready is kept as its own register equal to (state == IDLE)
  // so it leaves the block straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      ready     <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rdata     <= '0;
      drop      <= 1'b0;
      req_op    <= OP_RD;
      req_addr  <= '0;
      req_wdata <= '0;
      req_strb  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;

      if (both_req || (any_req && (state != IDLE))) begin
        drop <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            req_op    <= in_op;
            req_addr  <= addr;
            req_wdata <= wdata;
            req_strb  <= in_strb;
            ready     <= 1'b0;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state   <= WAIT;
              lat_cnt <= CW'(1);
            end
          end
        end
        WAIT: begin
          if (lat_cnt == CW'(LATENCY - 1)) begin
            state <= RESP;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        RESP: begin
          state   <= IDLE;
          lat_cnt <= '0;
          ready   <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          lat_cnt <= '0;
          ready   <= 1'b1;
        end
      endcase

      // Response is produced on the RESP-entry edge so rsp_valid, rsp_err
      // and rdata all appear together in the RESP cycle. A write response
      // leaves rdata holding the last read result.
      if (enter_resp) begin
        rsp_valid <= 1'b1;
        rsp_err   <= cur_err;
        if (cur_op == OP_RD) begin
          rdata <= cur_err ? '0 : ram_rdata;
        end
      end
    end
  end

endmodule
